// File: rtl/sync_fifo_asym.sv
// sync_fifo_asym: single-clock FIFO with independent write and read beat widths.
// Narrow words pack little-endian into wide ones (lowest slice first). The
// write side is a valid/ready slave. The read side is a first-word-fall-through
// valid/ready master, fed by a prefetch engine that keeps an output buffer topped up.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   flush              synchronous clear of contents (same effect as rst)
//   s_data/s_valid/s_ready   write beat, accepted when s_valid && s_ready
//   m_data/m_valid/m_ready   read beat, FWFT, consumed when m_valid && m_ready
//   level              stored narrow units, including in-flight and prefetched data
//   almost_full        level >= ALMOST_FULL_THRESH
//   almost_empty       level <= ALMOST_EMPTY_THRESH
module sync_fifo_asym #(
  parameter int unsigned WR_DATA_WIDTH       = 8,
  parameter int unsigned RD_DATA_WIDTH       = 32,
  parameter int unsigned DEPTH_LOG2          = 9,
  parameter string       OUTPUT_REG          = "TRUE",
  parameter int unsigned ALMOST_FULL_THRESH  = (1 << DEPTH_LOG2) - 4,
  parameter int unsigned ALMOST_EMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WR_DATA_WIDTH-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [RD_DATA_WIDTH-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int unsigned NW       = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int unsigned MW       = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int unsigned WR_RATIO = WR_DATA_WIDTH / NW;
  localparam int unsigned RD_RATIO = RD_DATA_WIDTH / NW;
  localparam int unsigned WR_LOG   = $clog2(WR_RATIO);
  localparam int unsigned RD_LOG   = $clog2(RD_RATIO);
  // One of the two ratios is 1, so the sum is the log of the wide/narrow ratio.
  localparam int unsigned MAX_LOG  = WR_LOG + RD_LOG;
  localparam int unsigned CAP      = 1 << DEPTH_LOG2;
  localparam int unsigned LW       = DEPTH_LOG2 + 1;
  localparam int unsigned WAW      = DEPTH_LOG2 - WR_LOG;
  localparam int unsigned RAW      = DEPTH_LOG2 - RD_LOG;
  localparam int unsigned MAW      = DEPTH_LOG2 - MAX_LOG;
  localparam int unsigned MDEPTH   = 1 << MAW;
  localparam int unsigned LAT      = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int          BUF      = int'(LAT) + 1;
  localparam int unsigned CW       = 3;

  logic                     clr_c;
  logic                     wr_fire_c;
  logic                     rd_fire_c;
  logic                     issue_c;

  logic [WAW-1:0]           wr_ptr_q;
  logic [RAW-1:0]           rd_ptr_q;
  logic [LW-1:0]            level_q, level_d;
  logic                     af_q, ae_q;

  logic [MW-1:0]            mem_q [MDEPTH];

  logic                     v1_q;
  logic [RD_DATA_WIDTH-1:0] beat1_c;
  logic                     pipe_v_c;
  logic [RD_DATA_WIDTH-1:0] pipe_d_c;
  logic [CW-1:0]            inflight_c;
  logic [CW-1:0]            pending_c;

  logic [RD_DATA_WIDTH-1:0] buf_q [BUF];
  logic [RD_DATA_WIDTH-1:0] buf_d [BUF];
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     mv_q;

  assign clr_c = rst | flush;

  // Space check uses registered level only; a same-cycle read does not free room.
  assign s_ready   = !rst && !flush && ((LW'(CAP) - level_q) >= LW'(WR_RATIO));
  assign wr_fire_c = s_valid && s_ready;
  assign rd_fire_c = mv_q && m_ready;

  // Reads issued but not yet consumed: buffered beats plus beats in the RAM pipeline.
  assign pending_c = cnt_q + inflight_c;

  // Issue when one more complete beat is committed beyond everything already
  // issued, and the buffer has room counting in-flight reads and a same-cycle pop.
  assign issue_c = !clr_c
                && (32'(level_q) >= RD_RATIO * (32'(pending_c) + 32'd1))
                && ((pending_c - CW'(rd_fire_c)) < CW'(BUF));

  // RAM write port: full-word write or narrow slice write into a wide word.
  generate
    if (WR_LOG >= RD_LOG) begin : g_wr_full
      always_ff @(posedge clk) begin
        if (wr_fire_c) mem_q[wr_ptr_q] <= s_data;
      end
    end else begin : g_wr_slice
      logic [MAW-1:0]    waddr_c;
      logic [RD_LOG-1:0] wsel_c;
      assign waddr_c = wr_ptr_q[WAW-1:RD_LOG];
      assign wsel_c  = wr_ptr_q[RD_LOG-1:0];
      always_ff @(posedge clk) begin
        if (wr_fire_c) mem_q[waddr_c][wsel_c*NW +: NW] <= s_data;
      end
    end
  endgenerate

  // RAM read port: registered read; narrow reads select a slice of the wide word.
  generate
    if (RD_LOG >= WR_LOG) begin : g_rd_full
      logic [RD_DATA_WIDTH-1:0] word1_q;
      always_ff @(posedge clk) begin
        if (issue_c) word1_q <= mem_q[rd_ptr_q];
      end
      assign beat1_c = word1_q;
    end else begin : g_rd_slice
      logic [MAW-1:0]    raddr_c;
      logic [WR_LOG-1:0] rsel_c;
      logic [MW-1:0]     word1_q;
      logic [WR_LOG-1:0] sel1_q;
      assign raddr_c = rd_ptr_q[RAW-1:WR_LOG];
      assign rsel_c  = rd_ptr_q[WR_LOG-1:0];
      always_ff @(posedge clk) begin
        if (issue_c) begin
          word1_q <= mem_q[raddr_c];
          sel1_q  <= rsel_c;
        end
      end
      assign beat1_c = word1_q[sel1_q*NW +: NW];
    end
  endgenerate

  // Optional RAM output register stage.
  generate
    if (LAT == 2) begin : g_oreg
      logic                     v2_q;
      logic [RD_DATA_WIDTH-1:0] d2_q;
      always_ff @(posedge clk) begin
        if (clr_c) v2_q <= 1'b0;
        else       v2_q <= v1_q;
        d2_q <= beat1_c;
      end
      assign pipe_v_c   = v2_q;
      assign pipe_d_c   = d2_q;
      assign inflight_c = CW'(v1_q) + CW'(v2_q);
    end else begin : g_noreg
      assign pipe_v_c   = v1_q;
      assign pipe_d_c   = beat1_c;
      assign inflight_c = CW'(v1_q);
    end
  endgenerate

  // Level bookkeeping: net change of both handshakes.
  always_comb begin
    level_d = level_q;
    if (wr_fire_c) level_d = level_d + LW'(WR_RATIO);
    if (rd_fire_c) level_d = level_d - LW'(RD_RATIO);
  end

  // Output buffer: head always at index 0, pop shifts down, push lands after the tail.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (rd_fire_c) begin
      for (int i = 0; i < BUF - 1; i++) buf_d[i] = buf_q[i+1];
      buf_d[BUF-1] = '0;
      cnt_d        = cnt_q - CW'(1);
    end
    if (pipe_v_c) begin
      for (int i = 0; i < BUF; i++) begin
        if (CW'(i) == cnt_d) buf_d[i] = pipe_d_c;
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  // Control state; rst and flush both discard pointers, level, buffer and in-flight reads.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      v1_q     <= 1'b0;
      cnt_q    <= '0;
      mv_q     <= 1'b0;
      for (int i = 0; i < BUF; i++) buf_q[i] <= '0;
    end else begin
      if (wr_fire_c) wr_ptr_q <= wr_ptr_q + WAW'(1);
      if (issue_c)   rd_ptr_q <= rd_ptr_q + RAW'(1);
      level_q <= level_d;
      af_q    <= (32'(level_d) >= ALMOST_FULL_THRESH);
      ae_q    <= (32'(level_d) <= ALMOST_EMPTY_THRESH);
      v1_q    <= issue_c;
      cnt_q   <= cnt_d;
      mv_q    <= (cnt_d != '0);
      for (int i = 0; i < BUF; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign m_data       = buf_q[0];
  assign m_valid      = mv_q;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_sync_fifo_asym.sv
// Testbench for sync_fifo_asym: three configurations (8->32 with output register,
// 32->8 without, 8->8 with), directed vector table, corner sequences and a
// randomized stream against a queue-based reference model.
module tb_sync_fifo_asym;

  logic clk, rst, flush;

  logic [7:0]  a_sd;  logic a_sv, a_sr, a_mv, a_mr, a_af, a_ae;
  logic [31:0] a_md;  logic [4:0] a_lvl;
  logic [31:0] b_sd;  logic b_sv, b_sr, b_mv, b_mr, b_af, b_ae;
  logic [7:0]  b_md;  logic [4:0] b_lvl;
  logic [7:0]  c_sd;  logic c_sv, c_sr, c_mv, c_mr, c_af, c_ae;
  logic [7:0]  c_md;  logic [4:0] c_lvl;

  int n_chk = 0;
  int n_err = 0;

  sync_fifo_asym #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(32), .DEPTH_LOG2(4), .OUTPUT_REG("TRUE"),
                   .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .s_data(a_sd), .s_valid(a_sv), .s_ready(a_sr),
    .m_data(a_md), .m_valid(a_mv), .m_ready(a_mr), .level(a_lvl),
    .almost_full(a_af), .almost_empty(a_ae));

  sync_fifo_asym #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(8), .DEPTH_LOG2(4), .OUTPUT_REG("FALSE"),
                   .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .s_data(b_sd), .s_valid(b_sv), .s_ready(b_sr),
    .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr), .level(b_lvl),
    .almost_full(b_af), .almost_empty(b_ae));

  sync_fifo_asym #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(8), .DEPTH_LOG2(4), .OUTPUT_REG("TRUE"),
                   .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .s_data(c_sd), .s_valid(c_sv), .s_ready(c_sr),
    .m_data(c_md), .m_valid(c_mv), .m_ready(c_mr), .level(c_lvl),
    .almost_full(c_af), .almost_empty(c_ae));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, sv;
    logic [7:0]  sd;
    logic        mr;
    logic        sr, mv, chk_md;
    logic [31:0] md;
    logic [4:0]  lvl;
    logic        af, ae;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic r, f, sv, input logic [7:0] sd, input logic mr,
                     input logic sr, mv, cm, input logic [31:0] md, input logic [4:0] lv,
                     input logic af, ae);
    vec_t v;
    v.rst = r; v.flush = f; v.sv = sv; v.sd = sd; v.mr = mr;
    v.sr = sr; v.mv = mv; v.chk_md = cm; v.md = md; v.lvl = lv; v.af = af; v.ae = ae;
    tbl.push_back(v);
  endtask

  // Store 10 bytes (second beat in flight), clear by rst or flush, then reuse.
  task automatic clear_test(input bit use_rst);
    int lat;
    string nm;
    nm = use_rst ? "rst" : "flush";
    a_mr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_sv = 1'b1; a_sd = 8'(8'h30 + i);
      tick();
    end
    #1 chk($sformatf("%s pre level", nm), 32'(a_lvl), 10);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    a_sv = 1'b1; a_sd = 8'hEE;
    #1 chk($sformatf("%s s_ready in clear", nm), 32'(a_sr), 0);
    tick();
    rst = 1'b0; flush = 1'b0; a_sv = 1'b0;
    #1;
    chk($sformatf("%s level", nm), 32'(a_lvl), 0);
    chk($sformatf("%s m_valid", nm), 32'(a_mv), 0);
    chk($sformatf("%s almost_empty", nm), 32'(a_ae), 1);
    chk($sformatf("%s almost_full", nm), 32'(a_af), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1 chk($sformatf("%s no stale valid", nm), 32'(a_mv), 0);
    end
    for (int i = 0; i < 4; i++) begin
      a_sv = 1'b1; a_sd = 8'(i + 1);
      tick();
    end
    a_sv = 1'b0;
    lat = 0;
    #1;
    while (!a_mv && lat < 10) begin
      tick(); #1; lat++;
    end
    chk($sformatf("%s refill latency", nm), 32'(lat), 3);
    chk($sformatf("%s refill data", nm), a_md, 32'h04030201);
    chk($sformatf("%s refill level", nm), 32'(a_lvl), 4);
    a_mr = 1'b1;
    tick();
    a_mr = 1'b0;
    #1 chk($sformatf("%s drained level", nm), 32'(a_lvl), 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] exp_w;
    logic [7:0]  q[$];
    int lat, lvl_m, tx, rx, cyc;
    logic wr, rd;

    rst = 1'b1; flush = 1'b0;
    a_sv = 0; a_sd = '0; a_mr = 0;
    b_sv = 0; b_sd = '0; b_mr = 0;
    c_sv = 0; c_sd = '0; c_mr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    //   rst f sv sd      mr   sr mv cm md            lv af ae
    add(1, 0, 0, 8'h00, 0,   0, 0, 1, 32'h0,        0, 0, 1);
    add(0, 0, 1, 8'h11, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    add(0, 0, 1, 8'h22, 0,   1, 0, 0, 32'h0,        1, 0, 1);
    add(0, 0, 1, 8'h33, 0,   1, 0, 0, 32'h0,        2, 0, 1);
    add(0, 0, 1, 8'h44, 0,   1, 0, 0, 32'h0,        3, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        4, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        4, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        4, 0, 1);
    add(0, 0, 0, 8'h00, 1,   1, 1, 1, 32'h44332211, 4, 0, 1);
    add(0, 0, 1, 8'h55, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    add(0, 0, 1, 8'h66, 0,   1, 0, 0, 32'h0,        1, 0, 1);
    add(0, 0, 1, 8'h77, 0,   1, 0, 0, 32'h0,        2, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        3, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        3, 0, 1);
    add(0, 0, 1, 8'h88, 0,   1, 0, 0, 32'h0,        3, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        4, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        4, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        4, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 1, 1, 32'h88776655, 4, 0, 1);
    add(0, 0, 0, 8'h00, 1,   1, 1, 1, 32'h88776655, 4, 0, 1);
    add(0, 0, 0, 8'h00, 0,   1, 0, 0, 32'h0,        0, 0, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush;
      a_sv = tbl[i].sv; a_sd = tbl[i].sd; a_mr = tbl[i].mr;
      #1;
      chk($sformatf("tbl%0d s_ready", i), 32'(a_sr), 32'(tbl[i].sr));
      chk($sformatf("tbl%0d m_valid", i), 32'(a_mv), 32'(tbl[i].mv));
      if (tbl[i].chk_md) chk($sformatf("tbl%0d m_data", i), a_md, tbl[i].md);
      chk($sformatf("tbl%0d level", i), 32'(a_lvl), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d almost_full", i), 32'(a_af), 32'(tbl[i].af));
      chk($sformatf("tbl%0d almost_empty", i), 32'(a_ae), 32'(tbl[i].ae));
      tick();
    end
    rst = 1'b0; flush = 1'b0; a_sv = 1'b0; a_mr = 1'b0;

    // Fill A to capacity with the consumer stalled, then drain.
    for (int i = 0; i < 16; i++) begin
      a_sv = 1'b1; a_sd = 8'(i + 1);
      #1;
      chk($sformatf("fill%0d s_ready", i), 32'(a_sr), 1);
      chk($sformatf("fill%0d level", i), 32'(a_lvl), 32'(i));
      chk($sformatf("fill%0d almost_full", i), 32'(a_af), 32'(i >= 12));
      chk($sformatf("fill%0d almost_empty", i), 32'(a_ae), 32'(i <= 4));
      tick();
    end
    a_sv = 1'b1; a_sd = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full s_ready", 32'(a_sr), 0);
      chk("full level", 32'(a_lvl), 16);
      chk("full almost_full", 32'(a_af), 1);
      chk("full almost_empty", 32'(a_ae), 0);
      chk("full m_valid", 32'(a_mv), 1);
      tick();
    end
    a_sv = 1'b0; a_mr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_w = {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)};
      #1;
      chk($sformatf("drain%0d m_valid", k), 32'(a_mv), 1);
      chk($sformatf("drain%0d m_data", k), a_md, exp_w);
      tick();
    end
    #1;
    chk("drained m_valid", 32'(a_mv), 0);
    chk("drained level", 32'(a_lvl), 0);
    chk("drained s_ready", 32'(a_sr), 1);
    a_mr = 1'b0;
    tick();

    clear_test(1'b0);
    clear_test(1'b1);

    // B: 32-bit writes unpacked into 8-bit reads, no output register.
    #1;
    chk("B reset level", 32'(b_lvl), 0);
    chk("B reset m_valid", 32'(b_mv), 0);
    chk("B reset m_data", 32'(b_md), 0);
    chk("B reset almost_full", 32'(b_af), 0);
    chk("B reset almost_empty", 32'(b_ae), 1);
    w = 32'hA1B2C3D4;
    b_sv = 1'b1; b_sd = w;
    chk("B s_ready", 32'(b_sr), 1);
    tick();
    b_sv = 1'b0;
    lat = 0;
    #1;
    while (!b_mv && lat < 10) begin
      tick(); #1; lat++;
    end
    chk("B latency", 32'(lat), 2);
    chk("B level", 32'(b_lvl), 4);
    b_mr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("B beat%0d valid", k), 32'(b_mv), 1);
      chk($sformatf("B beat%0d data", k), 32'(b_md), 32'(w[8*k +: 8]));
      tick();
    end
    #1;
    chk("B after beats m_valid", 32'(b_mv), 0);
    chk("B after beats level", 32'(b_lvl), 0);
    b_mr = 1'b0;

    // B: two random words, random m_ready; head must always be the oldest byte.
    q.delete();
    for (int j = 0; j < 2; j++) begin
      w = $urandom;
      b_sv = 1'b1; b_sd = w;
      #1 chk("B stall s_ready", 32'(b_sr), 1);
      for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
      tick();
    end
    b_sv = 1'b0;
    #1;
    chk("B two-word level", 32'(b_lvl), 8);
    chk("B two-word almost_empty", 32'(b_ae), 0);
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      b_mr = 1'($urandom_range(0, 1));
      #1;
      if (b_mv) begin
        chk("B stall data", 32'(b_md), 32'(q[0]));
        if (b_mr) void'(q.pop_front());
      end
      tick();
      cyc++;
    end
    chk("B drain complete", 32'(q.size()), 0);
    b_mr = 1'b0;

    // C: 100 incrementing bytes through a 16-deep 8->8 FIFO with random handshakes.
    q.delete();
    lvl_m = 0; tx = 0; rx = 0; cyc = 0;
    while (rx < 100 && cyc < 5000) begin
      c_sv = (tx < 100) && ($urandom_range(0, 99) < 60);
      c_sd = 8'(tx);
      c_mr = ($urandom_range(0, 99) < ((cyc < 150) ? 30 : 70));
      #1;
      chk("C level", 32'(c_lvl), 32'(lvl_m));
      chk("C level bound", 32'(c_lvl <= 5'd16), 1);
      chk("C s_ready", 32'(c_sr), 32'((16 - lvl_m) >= 1));
      chk("C almost_full", 32'(c_af), 32'(lvl_m >= 12));
      chk("C almost_empty", 32'(c_ae), 32'(lvl_m <= 4));
      wr = c_sv && c_sr;
      rd = c_mv && c_mr;
      if (c_mv) begin
        if (q.size() == 0) chk("C valid while empty", 32'(c_mv), 0);
        else               chk("C data", 32'(c_md), 32'(q[0]));
      end
      if (rd && q.size() > 0) begin
        void'(q.pop_front());
        rx++;
      end
      if (wr) begin
        q.push_back(8'(tx));
        tx++;
      end
      lvl_m = lvl_m + int'(wr) - int'(rd);
      tick();
      cyc++;
    end
    c_sv = 1'b0; c_mr = 1'b0;
    chk("C received all", 32'(rx), 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_asym.md
# sync_fifo_asym

Single-clock FIFO with independent write and read data widths, built on the same RAM style as the asymmetric simple dual-port RAM. Narrow words pack into wide ones, lowest slice first. The write side is a valid/ready slave and the read side is a first-word-fall-through valid/ready master. It sits between width-mismatched datapath stages, for example 8-bit byte streams feeding 32-bit processing. Occupancy, almost-full/empty flags and a synchronous flush are provided.

## Interface
- WR_DATA_WIDTH, 8, write beat width
- RD_DATA_WIDTH, 32, read beat width; max(WR,RD)/min(WR,RD) must be a power of two (1 allowed)
- DEPTH_LOG2, 9, capacity = 2**DEPTH_LOG2 narrow units (narrow = min width); must be ≥ log2(ratio)+1
- OUTPUT_REG, "TRUE", "TRUE" gives RAM read latency L=2, "FALSE" gives L=1
- ALMOST_FULL_THRESH, 2**DEPTH_LOG2-4, almost_full when level ≥ this (narrow units)
- ALMOST_EMPTY_THRESH, 4, almost_empty when level ≤ this (narrow units)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents, one-cycle pulse sufficient
- s_data  in  WR_DATA_WIDTH  write data
- s_valid  in  1  write request
- s_ready  out  1  write accepted when s_valid && s_ready
- m_data  out  RD_DATA_WIDTH  read data, FWFT
- m_valid  out  1  m_data holds a complete read beat
- m_ready  in  1  consumer accepts when m_valid && m_ready
- level  out  DEPTH_LOG2+1  stored narrow units, including in-flight and prefetched data
- almost_full  out  1  level ≥ ALMOST_FULL_THRESH
- almost_empty  out  1  level ≤ ALMOST_EMPTY_THRESH

## Operation
- WR_RATIO = WR/narrow and RD_RATIO = RD/narrow; one of the two is 1.
- Packing is little-endian:
  - Narrow-to-wide: the k-th narrow word written lands in m_data[k*W +: W].
  - Wide-to-narrow: s_data[k*W +: W] is read out k-th.
- Write and read pointers are kept in their own beat units and wrap modulo capacity with no special case.
- level is registered.
  - Each cycle it updates by +WR_RATIO·(write handshake) − RD_RATIO·(read handshake).
  - Simultaneous handshakes apply the net change.
- s_ready = !rst && !flush && (2**DEPTH_LOG2 − level ≥ WR_RATIO), computed from registered level only. A same-cycle read does not free space.
- A read beat becomes eligible only once RD_RATIO narrow units have been committed. A partial wide word never raises m_valid.
- Prefetch:
  - The read-side engine issues RAM reads into an output buffer of L+1 entries.
  - It issues whenever a complete beat is available and the buffer has space counting in-flight reads.
  - This sustains one m beat per cycle under continuous m_ready.
- While m_valid && !m_ready, m_data holds stable.
- rst and flush have identical effect:
  - Pointers, level, prefetch buffer and in-flight reads are cleared.
  - A beat offered in that cycle is not accepted.
  - RAM contents are not cleared.

## Timing
- Outputs during and after reset: s_ready=0 while rst high, then 1 the first cycle after. m_valid=0, m_data=0, level=0, almost_full=0, almost_empty=1.
- Write latency: a write handshake at edge N makes level reflect it after edge N.
- Write-to-read latency: with the completing narrow write at edge N, m_valid goes high after edge N+1+L. That is 3 cycles for OUTPUT_REG "TRUE" and 2 for "FALSE".
- Read handshake at edge N: the next beat, if prefetched, is presented after edge N with no bubble.
- Full: s_ready falls after the edge that makes level > capacity−WR_RATIO. It rises the cycle after a read frees ≥ WR_RATIO units.
- Flags are registered alongside level and never lag it.
- Reset or flush in the middle of a prefetch discards the in-flight RAM data. m_valid stays 0 until fresh writes arrive.

## Test plan
- Config WR=8, RD=32, DEPTH_LOG2=4, OUTPUT_REG "TRUE". Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> m_valid high 3 cycles after the 0x44 handshake, m_data=0x44332211, level=4 before the read and 0 after.
- Same config, write 3 bytes only -> m_valid stays 0 and level=3. The 4th byte releases the beat with the normal latency.
- Same config, fill 16 bytes with m_ready=0 -> s_ready=0 after the 16th, level=16, almost_full=1, a 17th s_valid is held off. Then raise m_ready -> 4 beats on 4 consecutive cycles, after which s_ready returns.
- Config WR=32, RD=8. Write 0xA1B2C3D4 -> reads 0xD4, 0xC3, 0xB2, 0xA1 on consecutive cycles, m_valid drops after the 4th. Toggling m_ready randomly keeps m_data stable while stalled.
- Wrap: WR=RD=8, DEPTH_LOG2=4, stream 100 incrementing bytes with random s_valid/m_ready -> output order and values match input exactly, and level never exceeds 16.
- Assert rst, then separately flush, with 10 bytes stored and a prefetch in flight -> next cycle level=0, m_valid=0, almost_empty=1. A write offered in the flush cycle is dropped and the next write reads back correctly.
